// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: decode-stage immediate generator.
// The instruction word and format select are decoded combinationally, then the
// XLEN-wide immediate, illegal-format flag and tag are registered behind a
// two-entry (main + skid) buffer so downstream stalls never drop or repeat data.
//
// Handshake: a transfer happens on an edge where valid && ready are both high
// on that side. in_ready is !skid_valid, a pure register output, so it never
// depends combinationally on out_ready. Once out_valid is high, out_* hold
// steady until the cycle that out_ready accepts them.
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  // Opcode bits carry no immediate information in any format.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  logic [31:0]      imm32;
  logic             imm_err;
  logic [XLEN-1:0]  imm_ext;

  logic             main_valid;
  logic [XLEN-1:0]  main_imm;
  logic             main_err;
  logic [TAG_W-1:0] main_tag;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic             skid_err;
  logic [TAG_W-1:0] skid_tag;

  logic in_xfer;
  logic main_free;

  // Decode the 32-bit immediate for the selected format; 111 flags an error.
  always_comb begin
    imm32   = '0;
    imm_err = 1'b0;
    case (ImmSrc)
      3'b000:  imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b001:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      3'b011:  imm32 = '0;
      3'b100:  imm32 = {instr[31:12], 12'b0};
      3'b101:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      3'b110:  imm32 = {27'b0, instr[19:15]};
      default: imm_err = 1'b1;
    endcase
  end

  // Widen to XLEN. Bit 31 is already 0 for the R, Z and illegal cases, so a
  // single sign-replication covers both signed and zero-extended formats.
  always_comb begin
    imm_ext        = '0;
    imm_ext[31:0]  = imm32;
    for (int i = 32; i < XLEN; i++) begin
      imm_ext[i] = imm32[31];
    end
  end

  assign in_xfer   = in_valid && in_ready;
  // Main can take new data when empty or when its contents leave this cycle.
  assign main_free = !main_valid || out_ready;

  // Main/skid storage: skid always drains into main before any new input,
  // which keeps the order strictly FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_err   <= 1'b0;
      main_tag   <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_err   <= 1'b0;
      skid_tag   <= '0;
    end else if (flush) begin
      // Data fields are left as-is; only the valid bits matter.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // in_ready is low while skid is valid, so no input can arrive here.
        main_valid <= 1'b1;
        main_imm   <= skid_imm;
        main_err   <= skid_err;
        main_tag   <= skid_tag;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_xfer;
        if (in_xfer) begin
          main_imm <= imm_ext;
          main_err <= imm_err;
          main_tag <= in_tag;
        end
      end
    end else if (in_xfer) begin
      // Main is held by a stalled consumer: park the input in skid.
      skid_valid <= 1'b1;
      skid_imm   <= imm_ext;
      skid_err   <= imm_err;
      skid_tag   <= in_tag;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_imm   = main_imm;
  assign out_err   = main_err;
  assign out_tag   = main_tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: format decode at XLEN=32 and XLEN=64,
// backpressure ordering, flush, asynchronous reset and full-rate streaming.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic        out_err;
  logic [31:0] out_tag;

  logic        flush64;
  logic        in_valid64;
  logic        in_ready64;
  logic [31:0] instr64;
  logic [2:0]  imm_src64;
  logic [31:0] in_tag64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] out_imm64;
  logic        out_err64;
  logic [31:0] out_tag64;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];

  imm_extend_pipe #(.XLEN(32), .TAG_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .ImmSrc(imm_src), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_err(out_err), .out_tag(out_tag)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .instr(instr64), .ImmSrc(imm_src64), .in_tag(in_tag64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .out_imm(out_imm64), .out_err(out_err64), .out_tag(out_tag64)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_checks++;
    if (out_imm !== 32'h0 || out_err !== 1'b0 || out_tag !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got imm %h err %b tag %h expected 0 0 0",
               out_imm, out_err, out_tag);
    end
  endtask

  task automatic test_formats();
    logic [31:0] t_instr[9];
    logic [2:0]  t_src[9];
    logic [31:0] t_exp[9];
    logic        t_err[9];
    t_instr[0] = 32'hFFF00093; t_src[0] = 3'b000; t_exp[0] = 32'hFFFFFFFF; t_err[0] = 1'b0;
    t_instr[1] = 32'hFE112C23; t_src[1] = 3'b001; t_exp[1] = 32'hFFFFFFF8; t_err[1] = 1'b0;
    // beq x0,x0,-4
    t_instr[2] = 32'hFE000EE3; t_src[2] = 3'b010; t_exp[2] = 32'hFFFFFFFC; t_err[2] = 1'b0;
    // beq x1,x2,+8
    t_instr[3] = 32'h00208463; t_src[3] = 3'b010; t_exp[3] = 32'h00000008; t_err[3] = 1'b0;
    t_instr[4] = 32'h00B50533; t_src[4] = 3'b011; t_exp[4] = 32'h00000000; t_err[4] = 1'b0;
    t_instr[5] = 32'h12345037; t_src[5] = 3'b100; t_exp[5] = 32'h12345000; t_err[5] = 1'b0;
    t_instr[6] = 32'h800000EF; t_src[6] = 3'b101; t_exp[6] = 32'hFFF00000; t_err[6] = 1'b0;
    t_instr[7] = 32'h000FD073; t_src[7] = 3'b110; t_exp[7] = 32'h0000001F; t_err[7] = 1'b0;
    t_instr[8] = 32'hFFFFFFFF; t_src[8] = 3'b111; t_exp[8] = 32'h00000000; t_err[8] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      instr    = t_instr[i];
      imm_src  = t_src[i];
      in_tag   = 32'h100 + i;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_tag !== 32'h100 + i) begin
        n_fail++;
        $display("FAIL fmt_valid_tag[%0d]: got valid %b tag %h expected 1 %h",
                 i, out_valid, out_tag, 32'h100 + i);
      end
      n_checks++;
      if (out_imm !== t_exp[i]) begin
        n_fail++;
        $display("FAIL fmt_imm[%0d]: got %h expected %h", i, out_imm, t_exp[i]);
      end
      n_checks++;
      if (out_err !== t_err[i]) begin
        n_fail++;
        $display("FAIL fmt_err[%0d]: got %b expected %b", i, out_err, t_err[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_xlen64();
    logic [31:0] t_instr[5];
    logic [2:0]  t_src[5];
    logic [63:0] t_exp[5];
    t_instr[0] = 32'hFE000EE3; t_src[0] = 3'b010; t_exp[0] = 64'hFFFFFFFFFFFFFFFC;
    t_instr[1] = 32'hFFF00093; t_src[1] = 3'b000; t_exp[1] = 64'hFFFFFFFFFFFFFFFF;
    t_instr[2] = 32'h80000037; t_src[2] = 3'b100; t_exp[2] = 64'hFFFFFFFF80000000;
    t_instr[3] = 32'h7FFFF0B7; t_src[3] = 3'b100; t_exp[3] = 64'h000000007FFFF000;
    t_instr[4] = 32'hFFFFFFFF; t_src[4] = 3'b110; t_exp[4] = 64'h000000000000001F;
    out_ready64 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid64 = 1'b1;
      instr64    = t_instr[i];
      imm_src64  = t_src[i];
      in_tag64   = 32'h200 + i;
      @(posedge clk); #1;
      in_valid64 = 1'b0;
      n_checks++;
      if (out_valid64 !== 1'b1 || out_imm64 !== t_exp[i] || out_err64 !== 1'b0
          || out_tag64 !== 32'h200 + i) begin
        n_fail++;
        $display("FAIL x64[%0d]: got v%b imm %h err %b tag %h expected v1 imm %h err 0 tag %h",
                 i, out_valid64, out_imm64, out_err64, out_tag64, t_exp[i], 32'h200 + i);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int          next_tag;
    int          recv;
    bit          stalled;
    logic [31:0] prev_imm;
    logic [31:0] prev_tag;
    logic [31:0] exp_tag;
    next_tag = 1;
    recv     = 0;
    stalled  = 0;
    prev_imm = '0;
    prev_tag = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (recv == 6 && next_tag > 6) break;
      out_ready = (cyc >= 3);
      in_valid  = (next_tag <= 6);
      instr     = {next_tag[11:0], 20'h00093};
      imm_src   = 3'b000;
      in_tag    = next_tag;
      n_checks++;
      if (in_ready !== (exp_q.size() < 2)) begin
        n_fail++;
        $display("FAIL bp_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_q.size() < 2);
      end
      n_checks++;
      if (out_valid !== (exp_q.size() > 0)) begin
        n_fail++;
        $display("FAIL bp_out_valid cyc %0d: got %b expected %b", cyc, out_valid, exp_q.size() > 0);
      end
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== prev_tag || out_imm !== prev_imm) begin
          n_fail++;
          $display("FAIL bp_stable cyc %0d: got v%b tag %h imm %h expected v1 tag %h imm %h",
                   cyc, out_valid, out_tag, out_imm, prev_tag, prev_imm);
        end
      end
      if (out_valid === 1'b1 && out_ready && exp_q.size() > 0) begin
        exp_tag = exp_q.pop_front();
        n_checks++;
        if (out_tag !== exp_tag || out_imm !== exp_tag) begin
          n_fail++;
          $display("FAIL bp_order cyc %0d: got tag %h imm %h expected %h",
                   cyc, out_tag, out_imm, exp_tag);
        end
        recv++;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(next_tag);
        next_tag++;
      end
      stalled  = (out_valid === 1'b1) && !out_ready;
      prev_imm = out_imm;
      prev_tag = out_tag;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (recv != 6 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d received expected 6", recv);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    imm_src   = 3'b000;
    in_valid  = 1'b1; instr = 32'h00B00093; in_tag = 32'd11;
    @(posedge clk); #1;
    in_valid  = 1'b1; instr = 32'h00C00093; in_tag = 32'd12;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: got in_ready %b out_valid %b expected 0 1", in_ready, out_valid);
    end
    flush = 1'b1;
    in_valid = 1'b1; instr = 32'h06300093; in_tag = 32'd99;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_empty: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_leak[%0d]: got out_valid %b tag %h expected 0", i, out_valid, out_tag);
      end
    end
    in_valid = 1'b1; instr = 32'h00D00093; in_tag = 32'd13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_tag !== 32'd13 || out_imm !== 32'd13) begin
      n_fail++;
      $display("FAIL flush_resume: got v%b tag %h imm %h expected v1 tag d 0000000d",
               out_valid, out_tag, out_imm);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    imm_src   = 3'b000;
    in_valid  = 1'b1; instr = 32'hFFF00093; in_tag = 32'd21;
    @(posedge clk); #1;
    in_valid  = 1'b1; instr = 32'h7FF00093; in_tag = 32'd22;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_flags: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
    end
    n_checks++;
    if (out_imm !== 32'h0 || out_tag !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_data: got imm %h tag %h expected 0 0", out_imm, out_tag);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1; instr = 32'h01F00093; in_tag = 32'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_tag !== 32'd31 || out_imm !== 32'h1F) begin
      n_fail++;
      $display("FAIL arst_first: got v%b tag %h imm %h expected v1 tag 1f imm 1f",
               out_valid, out_tag, out_imm);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] cur_instr;
    logic [31:0] prev_exp;
    prev_exp  = '0;
    out_ready = 1'b1;
    imm_src   = 3'b100;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 32'd40 + i - 1 || out_imm !== prev_exp
            || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got v%b tag %h imm %h rdy %b expected v1 tag %h imm %h rdy 1",
                   i, out_valid, out_tag, out_imm, in_ready, 32'd40 + i - 1, prev_exp);
        end
      end
      if (i < 8) begin
        cur_instr = {20'(i * 4097 + 1), 12'h037};
        prev_exp  = {cur_instr[31:12], 12'h000};
        in_valid  = 1'b1;
        instr     = cur_instr;
        in_tag    = 32'd40 + i;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got out_valid %b expected 0", out_valid);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    instr       = '0;
    imm_src     = '0;
    in_tag      = '0;
    out_ready   = 1'b0;
    flush64     = 1'b0;
    in_valid64  = 1'b0;
    instr64     = '0;
    imm_src64   = '0;
    in_tag64    = '0;
    out_ready64 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_formats();
    test_xlen64();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
